// File: rtl/rf_access_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file; one access in flight.
// Optional WAIT-state watchdog is compiled in with `define RF_ARB_TIMEOUT_EN.
module rf_access_arbiter #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  res_n,

    input  logic                  m0_req,
    input  logic                  m0_wr,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_done,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_invalid,

    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_done,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_invalid,

    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic                  rf_read_en,
    output logic                  rf_write_en,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    input  logic                  rf_invalid_address,
    input  logic                  rf_access_complete
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]            req;
    logic                  pick;
    logic                  pick_wr;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [DATA_WIDTH-1:0] pick_wdata;

    logic last_reg;
    logic owner_reg;
    logic wr_reg;

    logic accept;
    logic finish;
    logic expire;
    logic timeout_hit;

    logic [1:0]            gnt_vec;
    logic [1:0]            done_vec;
    logic [1:0]            inv_vec;
    logic [DATA_WIDTH-1:0] rdata_vec [2];

    assign req = {m1_req, m0_req};

    // last_reg names the requester granted most recently; a tie goes to the other one.
    always_comb begin
        pick = req[1];
        if (req == 2'b11) begin
            pick = ~last_reg;
        end
    end

    assign pick_wr    = pick ? m1_wr    : m0_wr;
    assign pick_addr  = pick ? m1_addr  : m0_addr;
    assign pick_wdata = pick ? m1_wdata : m0_wdata;

`ifdef RF_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_reg;

    // cnt_reg equals the number of completed WAIT cycles so far.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_reg <= '0;
        end else if (state_reg == ISSUE) begin
            cnt_reg <= '0;
        end else if (state_reg == WAIT) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_out_of_range
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        expire     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (rf_access_complete) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Register-file side: strobes live only in ISSUE, address/data stay put until the next accept.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            last_reg      <= 1'b1;
            owner_reg     <= 1'b0;
            wr_reg        <= 1'b0;
            rf_address    <= '0;
            rf_write_data <= '0;
            rf_read_en    <= 1'b0;
            rf_write_en   <= 1'b0;
        end else begin
            rf_read_en  <= accept & ~pick_wr;
            rf_write_en <= accept &  pick_wr;
            if (accept) begin
                last_reg      <= pick;
                owner_reg     <= pick;
                wr_reg        <= pick_wr;
                rf_address    <= pick_addr;
                rf_write_data <= pick_wdata;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        logic                  gnt_reg;
        logic                  done_reg;
        logic                  inv_reg;
        logic [DATA_WIDTH-1:0] rdata_reg;
        logic                  mine;
        logic                  close;

        assign mine  = (owner_reg == 1'(gi));
        assign close = (finish | expire) & mine;

        always_ff @(posedge clk or negedge res_n) begin
            if (!res_n) begin
                gnt_reg   <= 1'b0;
                done_reg  <= 1'b0;
                inv_reg   <= 1'b0;
                rdata_reg <= '0;
            end else begin
                gnt_reg  <= accept & (pick == 1'(gi));
                done_reg <= close;
                // Result registers are touched only by this requester's own completion.
                if (close) begin
                    rdata_reg <= (expire | wr_reg) ? '0 : rf_read_data;
                    inv_reg   <= expire | rf_invalid_address;
                end
            end
        end

        assign gnt_vec[gi]   = gnt_reg;
        assign done_vec[gi]  = done_reg;
        assign inv_vec[gi]   = inv_reg;
        assign rdata_vec[gi] = rdata_reg;
    end

    assign m0_gnt     = gnt_vec[0];
    assign m0_done    = done_vec[0];
    assign m0_invalid = inv_vec[0];
    assign m0_rdata   = rdata_vec[0];

    assign m1_gnt     = gnt_vec[1];
    assign m1_done    = done_vec[1];
    assign m1_invalid = inv_vec[1];
    assign m1_rdata   = rdata_vec[1];

endmodule

// File: doc/rf_access_arbiter.md
RF_ACCESS_ARBITER -- requirements
Module: rf_access_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 2, register-file word address width.
REQ-002 Parameter: DATA_WIDTH, 64, register-file data width.
REQ-003 Parameter: TIMEOUT_CYCLES, 16, WAIT-state cycle limit; used only with RF_ARB_TIMEOUT_EN.
REQ-004 The block SHALL use one clock, clk, and an asynchronous, active-low reset, res_n.
REQ-005 Port: clk  in  1  clock, rising edge.
REQ-006 Port: res_n  in  1  asynchronous active-low reset.
REQ-007 Per requester x in {0,1}, the block SHALL provide these ports:
- mx_req  in  1  request; held high until mx_gnt.
- mx_wr  in  1  1 = write, 0 = read.
- mx_addr  in  ADDR_WIDTH  word address.
- mx_wdata  in  DATA_WIDTH  write data.
- mx_gnt  out  1  one-cycle accept pulse.
- mx_done  out  1  one-cycle completion pulse.
- mx_rdata  out  DATA_WIDTH  read data, valid with mx_done.
- mx_invalid  out  1  error flag, valid with mx_done.
REQ-008 The block SHALL provide these register-file-side ports:
- rf_address  out  ADDR_WIDTH
- rf_read_en  out  1
- rf_write_en  out  1
- rf_write_data  out  DATA_WIDTH
- rf_read_data  in  DATA_WIDTH
- rf_invalid_address  in  1
- rf_access_complete  in  1
REQ-009 All outputs SHALL be registered.

Function
REQ-010 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-011 In IDLE with any mx_req high at a clock edge, the block SHALL select one requester round-robin, latch its wr/addr/wdata and go to ISSUE.
- If both requesters are high, the one not granted last wins.
- After reset, m0 has priority.
REQ-012 In ISSUE, the block SHALL assert mx_gnt of the winner for exactly one cycle and, in the same cycle, exactly one of rf_write_en (wr=1) or rf_read_en (wr=0), then go to WAIT.
REQ-013 rf_address and rf_write_data SHALL hold the latched values from ISSUE through the cycle in which rf_access_complete is sampled.
REQ-014 In WAIT, rf_read_en and rf_write_en SHALL be 0.
REQ-015 On rf_access_complete=1 in WAIT, the block SHALL capture the result and go to IDLE.
- Next cycle: winner's mx_done=1, mx_rdata = rf_read_data (0 for writes), mx_invalid = rf_invalid_address.
REQ-016 mx_rdata and mx_invalid SHALL hold their values until that requester's next mx_done.
REQ-017 The non-winning requester's outputs SHALL be unaffected.
REQ-018 rf_access_complete seen in IDLE or ISSUE SHALL be ignored.
REQ-019 At most one access SHALL be outstanding at any time.
- Minimum request-to-done latency with a one-cycle register file: 4 cycles.
- Back-to-back accesses: new IDLE sampling on the cycle mx_done is driven.
REQ-020 A requester deasserting mx_req before mx_gnt SHALL be allowed; the request is dropped if not yet sampled.

Reset
REQ-021 While res_n=0, regardless of clock, the block SHALL immediately:
- force the state to IDLE;
- drive all outputs to 0;
- set the round-robin pointer to favour m0;
- clear the timeout counter.
REQ-022 A reset during ISSUE or WAIT SHALL abandon the access with no mx_done pulse.

Configuration
REQ-023 With RF_ARB_TIMEOUT_EN defined, a counter SHALL clear on entering WAIT and increment each WAIT cycle.
- When it reaches TIMEOUT_CYCLES without rf_access_complete, the FSM SHALL go to IDLE and pulse mx_done with mx_invalid=1 and mx_rdata=0.
- rf_access_complete on the same edge as the timeout SHALL take precedence as a normal completion.
REQ-024 Without RF_ARB_TIMEOUT_EN, WAIT SHALL persist indefinitely and no counter logic SHALL be synthesized.

Verification
REQ-025 Scenario (single write): m0 writes addr 1, data 64'h555AAA555AAA555A -> rf_write_en one cycle with rf_address=1; m0_done one cycle after rf_access_complete; m0_invalid=0; m0_rdata=0.
REQ-026 Scenario (single read): m1 reads addr 0, register file returns 64'h12ABCD -> m1_done=1 with m1_rdata=64'h12ABCD; m0_done stays 0.
REQ-027 Scenario (contention): m0_req and m1_req rise in the same cycle, held continuously -> order m0, m1, m0, m1; never two gnts in one cycle.
REQ-028 Scenario (invalid address): read addr 3 with rf_invalid_address=1 at completion -> mx_done=1, mx_invalid=1.
REQ-029 Scenario (reset mid-operation): res_n=0 asserted in WAIT -> all outputs 0 before the next edge; after release, m0 wins the first tie.
REQ-030 Scenario (timeout, RF_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16): rf_access_complete held 0 -> mx_done with mx_invalid=1 exactly 16 WAIT cycles after ISSUE; a subsequent request is serviced normally.
